// File: rtl/fc_stream_if.sv
// Handshake and configuration bundle for fc_stream.
// The design side uses the slave modport; the driving environment uses master.
interface fc_stream_if #(
    parameter int DW       = 16,
    parameter int IN_SIZE  = 3,
    parameter int OUT_SIZE = 2
);
    localparam int NW = IN_SIZE * OUT_SIZE;
    localparam int AW = (NW > 1) ? $clog2(NW) : 1;

    logic                     cfg_we;
    logic                     cfg_sel;
    logic [AW-1:0]            cfg_addr;
    logic [DW-1:0]            cfg_data;
    logic                     cfg_ready;

    logic                     in_valid;
    logic                     in_ready;
    logic [IN_SIZE*DW-1:0]    in_data;

    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_SIZE*DW-1:0]   out_data;

    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_data,
        output in_valid, in_data,
        output out_ready,
        input  cfg_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_addr, cfg_data,
        input  in_valid, in_data,
        input  out_ready,
        output cfg_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fc_stream.sv
// Streaming fully-connected layer: one input feature per cycle is MACed into every neuron.
// Define FC_STREAM_RELU_EN to clamp negative results to zero in the bias stage.
module fc_stream #(
    parameter int DW       = 16,
    parameter int IN_SIZE  = 3,
    parameter int OUT_SIZE = 2,
    parameter int FRAC     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       busy,
    fc_stream_if.slave bus
);
    localparam int NW    = IN_SIZE * OUT_SIZE;
    localparam int AW    = (NW > 1) ? $clog2(NW) : 1;
    localparam int KW    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int ACC_W = 2 * DW + $clog2(IN_SIZE);
    // One extra bit so the shifted bias can be added without wrapping.
    localparam int SUM_W = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [KW-1:0]           K_LAST  = KW'(IN_SIZE - 1);

    typedef enum logic [1:0] {IDLE, MAC, BIAS, HOLD} state_t;

    state_t state, state_nxt;

    logic signed [DW-1:0]    w_mem   [NW];
    logic signed [DW-1:0]    b_mem   [OUT_SIZE];
    logic signed [DW-1:0]    x_p0    [IN_SIZE];
    logic [KW-1:0]           k_p0;
    logic signed [ACC_W-1:0] acc_p1  [OUT_SIZE];
    logic signed [DW-1:0]    res_p2  [OUT_SIZE];

    logic signed [DW-1:0]    x_sel;
    logic signed [DW-1:0]    w_sel   [OUT_SIZE];
    logic signed [2*DW-1:0]  prod    [OUT_SIZE];
    logic signed [SUM_W-1:0] sum_b   [OUT_SIZE];
    logic signed [DW-1:0]    res_nxt [OUT_SIZE];
    logic [OUT_SIZE*DW-1:0]  out_flat;
    logic                    cfg_fire;

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SUM_W-1:0] v);
        if (v > SAT_MAX)
            return {1'b0, {(DW-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(DW-1){1'b0}}};
        else
            return v[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef FC_STREAM_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign bus.in_ready  = (state == IDLE);
    assign bus.cfg_ready = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign busy          = (state != IDLE);
    assign cfg_fire      = bus.cfg_we & bus.cfg_ready & en;

    always_comb begin
        out_flat = '0;
        for (int j = 0; j < OUT_SIZE; j++)
            out_flat[j*DW +: DW] = res_p2[j];
    end
    assign bus.out_data = out_flat;

    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                IDLE:    if (bus.in_valid) state_nxt = MAC;
                MAC:     if (k_p0 == K_LAST) state_nxt = BIAS;
                BIAS:    state_nxt = HOLD;
                HOLD:    if (bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Out-of-range addresses match no slot, so they fall through without effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NW; n++)       w_mem[n] <= '0;
            for (int j = 0; j < OUT_SIZE; j++) b_mem[j] <= '0;
        end else if (cfg_fire) begin
            for (int n = 0; n < NW; n++)
                if (!bus.cfg_sel && bus.cfg_addr == AW'(n))
                    w_mem[n] <= bus.cfg_data;
            for (int j = 0; j < OUT_SIZE; j++)
                if (bus.cfg_sel && bus.cfg_addr == AW'(j))
                    b_mem[j] <= bus.cfg_data;
        end
    end

    // Stage p0 -> p1: pick feature k and its weight row, form all neuron products.
    always_comb begin
        x_sel = '0;
        for (int j = 0; j < OUT_SIZE; j++) w_sel[j] = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (k_p0 == KW'(i)) begin
                x_sel = x_p0[i];
                for (int j = 0; j < OUT_SIZE; j++)
                    w_sel[j] = w_mem[i*OUT_SIZE + j];
            end
        end
        for (int j = 0; j < OUT_SIZE; j++)
            prod[j] = (2*DW)'(x_sel) * (2*DW)'(w_sel[j]);
    end

    // Stage p1 -> p2: add the aligned bias, rescale, saturate, optional ReLU.
    always_comb begin
        for (int j = 0; j < OUT_SIZE; j++) begin
            sum_b[j]   = SUM_W'(acc_p1[j]) + (SUM_W'(b_mem[j]) <<< FRAC);
            res_nxt[j] = relu(sat_dw(sum_b[j] >>> FRAC));
        end
    end

    always_ff @(posedge clk) begin
        if (en && state == IDLE && bus.in_valid)
            for (int i = 0; i < IN_SIZE; i++)
                x_p0[i] <= bus.in_data[i*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_p0 <= '0;
            for (int j = 0; j < OUT_SIZE; j++) begin
                acc_p1[j] <= '0;
                res_p2[j] <= '0;
            end
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        k_p0 <= '0;
                        for (int j = 0; j < OUT_SIZE; j++) acc_p1[j] <= '0;
                    end
                end
                MAC: begin
                    for (int j = 0; j < OUT_SIZE; j++)
                        acc_p1[j] <= acc_p1[j] + ACC_W'(prod[j]);
                    k_p0 <= (k_p0 == K_LAST) ? '0 : k_p0 + KW'(1);
                end
                BIAS: begin
                    for (int j = 0; j < OUT_SIZE; j++) res_p2[j] <= res_nxt[j];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_stream.sv
// Directed bench for fc_stream: transaction-level dot-product model plus literal expectations.
module tb_fc_stream;
    localparam int DW       = 16;
    localparam int IN_SIZE  = 3;
    localparam int OUT_SIZE = 2;
    localparam int FRAC     = 0;
    localparam int NW       = IN_SIZE * OUT_SIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic busy;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    longint                  w_m [NW];
    longint                  b_m [OUT_SIZE];
    bit                      busy_m = 1'b0;
    bit                      hold_m = 1'b0;
    int                      cnt_m  = 0;
    logic [OUT_SIZE*DW-1:0]  exp_m  = '0;
    logic [DW-1:0]           relu_n0;

    always #5 clk = ~clk;

    fc_stream_if #(.DW(DW), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) bus ();

    fc_stream #(.DW(DW), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .FRAC(FRAC)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .busy (busy),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_SIZE*DW-1:0] model_out(input logic [IN_SIZE*DW-1:0] xin);
        logic [OUT_SIZE*DW-1:0] r;
        longint acc, x, maxv, minv;
        maxv = (64'sd1 <<< (DW-1)) - 1;
        minv = -(64'sd1 <<< (DW-1));
        r = '0;
        for (int j = 0; j < OUT_SIZE; j++) begin
            acc = 0;
            for (int i = 0; i < IN_SIZE; i++) begin
                x = longint'($signed(xin[i*DW +: DW]));
                acc += x * w_m[i*OUT_SIZE + j];
            end
            acc = (acc + (b_m[j] <<< FRAC)) >>> FRAC;
            if (acc > maxv) acc = maxv;
            else if (acc < minv) acc = minv;
`ifdef FC_STREAM_RELU_EN
            if (acc < 0) acc = 0;
`endif
            r[j*DW +: DW] = acc[DW-1:0];
        end
        return r;
    endfunction

    // Transaction model: storage writes, dot product at acceptance, en-cycle latency count.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            busy_m = 1'b0;
            hold_m = 1'b0;
            cnt_m  = 0;
            for (int n = 0; n < NW; n++)       w_m[n] = 0;
            for (int j = 0; j < OUT_SIZE; j++) b_m[j] = 0;
        end else if (en) begin
            if (!busy_m) begin
                if (bus.cfg_we) begin
                    if (!bus.cfg_sel && int'(bus.cfg_addr) < NW)
                        w_m[int'(bus.cfg_addr)] = longint'($signed(bus.cfg_data));
                    else if (bus.cfg_sel && int'(bus.cfg_addr) < OUT_SIZE)
                        b_m[int'(bus.cfg_addr)] = longint'($signed(bus.cfg_data));
                end
                if (bus.in_valid) begin
                    exp_m  = model_out(bus.in_data);
                    busy_m = 1'b1;
                    cnt_m  = 0;
                end
            end else if (hold_m) begin
                if (bus.out_ready) begin
                    busy_m = 1'b0;
                    hold_m = 1'b0;
                end
            end else begin
                cnt_m++;
                if (cnt_m == IN_SIZE + 1) hold_m = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("in_ready",  64'(bus.in_ready),  64'(!busy_m));
            check("cfg_ready", 64'(bus.cfg_ready), 64'(!busy_m));
            check("busy",      64'(busy),          64'(busy_m));
            check("out_valid", 64'(bus.out_valid), 64'(hold_m));
            if (hold_m) check("out_data", 64'(bus.out_data), 64'(exp_m));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [2:0] addr, input logic [DW-1:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_addr = addr;
        bus.cfg_data = d;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic load_params(input logic [NW*DW-1:0] wv, input logic [OUT_SIZE*DW-1:0] bv);
        for (int n = 0; n < NW; n++)       cfg_write(1'b0, 3'(n), wv[n*DW +: DW]);
        for (int j = 0; j < OUT_SIZE; j++) cfg_write(1'b1, 3'(j), bv[j*DW +: DW]);
    endtask

    task automatic send(input logic [DW-1:0] x0, input logic [DW-1:0] x1, input logic [DW-1:0] x2);
        bus.in_data  = {x2, x1, x0};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Latency is counted in cycles from the accepting cycle to the first out_valid cycle.
    task automatic wait_out(input int stall_at, input int stall_len, output int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 60) begin
            en = !(n >= stall_at && n < stall_at + stall_len);
            tick();
            n++;
        end
        en  = 1'b1;
        lat = n + 1;
        check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1);
    end

    initial begin
        int lat;
`ifdef FC_STREAM_RELU_EN
        relu_n0 = 16'h0000;
`else
        relu_n0 = 16'hFFFB;
`endif
        bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

        tick(); tick();
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        check("rst_busy",      64'(busy),          64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        // W = [[1,2],[3,4],[5,6]], b = [10,-10], x = [1,1,1]
        load_params({16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, {16'hFFF6, 16'd10});
        send(16'd1, 16'd1, 16'd1);
        wait_out(0, 0, lat);
        check("basic_latency", 64'(lat), 64'd5);
        check("basic_n0", 64'(bus.out_data[15:0]),  64'd19);
        check("basic_n1", 64'(bus.out_data[31:16]), 64'd2);
        take();

        // Bias write and acceptance in the same cycle: new bias must be used.
        bus.cfg_we = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 16'd100;
        bus.in_data = {16'd1, 16'd1, 16'd1}; bus.in_valid = 1'b1;
        tick();
        bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
        wait_out(0, 0, lat);
        check("samecyc_n0", 64'(bus.out_data[15:0]),  64'd109);
        check("samecyc_n1", 64'(bus.out_data[31:16]), 64'd2);
        take();

        load_params({6{16'h7FFF}}, {16'd0, 16'd0});
        send(16'h7FFF, 16'h7FFF, 16'h7FFF);
        wait_out(0, 0, lat);
        check("sat_pos_n0", 64'(bus.out_data[15:0]),  64'h7FFF);
        check("sat_pos_n1", 64'(bus.out_data[31:16]), 64'h7FFF);
        take();
        send(16'h8001, 16'h8001, 16'h8001);
        wait_out(0, 0, lat);
        check("sat_neg_n0", 64'(bus.out_data[15:0]),  64'h8000);
        check("sat_neg_n1", 64'(bus.out_data[31:16]), 64'h8000);
        take();

        // W = [[-1,0],[0,0],[0,0]], x = [5,0,0]
        load_params({16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF}, {16'd0, 16'd0});
        send(16'd5, 16'd0, 16'd0);
        wait_out(0, 0, lat);
        check("relu_n0", 64'(bus.out_data[15:0]),  64'(relu_n0));
        check("relu_n1", 64'(bus.out_data[31:16]), 64'd0);

        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_in_ready",  64'(bus.in_ready),        64'd0);
            check("bp_out_valid", 64'(bus.out_valid),       64'd1);
            check("bp_out_n0",    64'(bus.out_data[15:0]),  64'(relu_n0));
        end
        en = 1'b0; bus.out_ready = 1'b1;
        tick();
        check("stall_hold_valid", 64'(bus.out_valid), 64'd1);
        en = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("xfer_out_valid", 64'(bus.out_valid), 64'd0);
        check("xfer_in_ready",  64'(bus.in_ready),  64'd1);

        send(16'd5, 16'd0, 16'd0);
        wait_out(1, 3, lat);
        check("stall_latency", 64'(lat), 64'd8);
        check("stall_n0", 64'(bus.out_data[15:0]), 64'(relu_n0));
        take();

        send(16'd5, 16'd0, 16'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        check("midrst_busy",      64'(busy),          64'd0);
        send(16'd7, 16'd7, 16'd7);
        wait_out(0, 0, lat);
        check("zero_w_n0", 64'(bus.out_data[15:0]),  64'd0);
        check("zero_w_n1", 64'(bus.out_data[31:16]), 64'd0);
        take();

        cfg_write(1'b0, 3'd0, 16'd3);
        send(16'd1, 16'd0, 16'd0);
        cfg_write(1'b0, 3'd0, 16'd100);
        cfg_write(1'b1, 3'd1, 16'd50);
        wait_out(0, 0, lat);
        check("busywr_n0", 64'(bus.out_data[15:0]),  64'd3);
        check("busywr_n1", 64'(bus.out_data[31:16]), 64'd0);
        take();

        cfg_write(1'b0, 3'd6, 16'd99);
        cfg_write(1'b0, 3'd7, 16'd99);
        cfg_write(1'b1, 3'd2, 16'd99);
        cfg_write(1'b1, 3'd3, 16'd99);
        send(16'd1, 16'd1, 16'd1);
        wait_out(0, 0, lat);
        check("oor_n0", 64'(bus.out_data[15:0]),  64'd3);
        check("oor_n1", 64'(bus.out_data[31:16]), 64'd0);
        take();

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_stream.md
FC_STREAM -- requirements
Module: fc_stream

Interface
REQ-001 SHALL have parameter DW, 16: signed two's-complement data, weight and bias width.
REQ-002 SHALL have parameter IN_SIZE, 3: input features, >=1.
REQ-003 SHALL have parameter OUT_SIZE, 2: output neurons, >=1.
REQ-004 SHALL have parameter FRAC, 0: fixed-point fraction bits, 0..DW-1.
REQ-005 SHALL have port clk  input  1: single clock, rising edge.
REQ-006 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-007 SHALL have port en  input  1: stall when low; all state holds.
REQ-008 SHALL have port cfg_we  input  1: parameter write strobe.
REQ-009 SHALL have port cfg_sel  input  1: 0 = weight, 1 = bias.
REQ-010 SHALL have port cfg_addr  input  clog2(IN_SIZE*OUT_SIZE): weight index i*OUT_SIZE+j, or bias index j.
REQ-011 SHALL have port cfg_data  input  DW: value to write.
REQ-012 SHALL have port cfg_ready  output  1: high only in IDLE.
REQ-013 SHALL have port in_valid / in_ready  input / output  1 each: input vector handshake.
REQ-014 SHALL have port in_data  input  IN_SIZE*DW: element i at bits [i*DW +: DW].
REQ-015 SHALL have port out_valid / out_ready  output / input  1 each: result handshake.
REQ-016 SHALL have port out_data  output  OUT_SIZE*DW: neuron j at [j*DW +: DW].
REQ-017 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, MAC, BIAS, HOLD. Each advance requires en=1.
REQ-019 IDLE: in_ready=1. in_valid&in_ready&en latches in_data, clears all OUT_SIZE accumulators, sets feature counter k=0 and moves to MAC.
REQ-020 MAC: each cycle, for every j, acc[j] += x[k]*W[k][j]. k increments; after k=IN_SIZE-1 the FSM moves to BIAS.
REQ-021 BIAS: r[j] = sat_DW((acc[j] + (sext(b[j]) << FRAC)) >>> FRAC) is registered into out_data, then the FSM moves to HOLD.
REQ-022 Accumulator width SHALL be 2*DW+clog2(IN_SIZE) so no intermediate overflow occurs. Saturation clamps to [-2^(DW-1), 2^(DW-1)-1]. Shift is arithmetic, truncating toward -inf.
REQ-023 HOLD: out_valid=1 and out_data is stable until out_valid&out_ready&en, then the FSM returns to IDLE. Latency is IN_SIZE+2 cycles from input acceptance to out_valid.
REQ-024 A cfg write is applied only when cfg_we&cfg_ready&en. A write at any other time is dropped silently. A weight address >= IN_SIZE*OUT_SIZE, or a bias address >= OUT_SIZE, is ignored.
REQ-025 A cfg write and an input acceptance in the same IDLE cycle: the write SHALL commit first, so the new value is used by that computation.
REQ-026 en=0 in any state: counter, accumulators, FSM and out_data hold. Handshake outputs keep their state-derived values, but no transfer occurs.
REQ-027 in_ready SHALL be 0 outside IDLE. A new vector is never accepted in the same cycle as an output transfer (no bubble-free overlap).

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, k=0, accumulators=0, out_data=0 and out_valid=0, which gives in_ready=1, cfg_ready=1 and busy=0 after the edge.
REQ-029 rst SHALL override en and any in-flight computation; a partially computed result is discarded.
REQ-030 Weight and bias storage SHALL reset to 0.

Configuration
REQ-031 With macro FC_STREAM_RELU_EN defined, the BIAS stage SHALL clamp negative saturated results to 0 (ReLU).
REQ-032 Without FC_STREAM_RELU_EN, results SHALL pass through unmodified, signed.

Verification
All scenarios use DW=16, IN_SIZE=3, OUT_SIZE=2, FRAC=0.
REQ-033 Basic: W = [[1,2],[3,4],[5,6]], b = [10,-10], x = [1,1,1]; accept on cycle c -> out_valid on c+5 with out_data = [19,2].
REQ-034 Saturation: all W=32767, x=[32767,32767,32767], b=0 -> both outputs 32767. Negating x -> both outputs -32768.
REQ-035 ReLU: W = [[-1,0],[0,0],[0,0]], x = [5,0,0], b = 0 -> out = [-5,0] without FC_STREAM_RELU_EN, and [0,0] with it.
REQ-036 Backpressure and stall: hold out_ready=0 for 10 cycles -> out_data stable and in_ready=0 throughout. Pulse en=0 for 3 cycles in MAC -> latency grows by 3 and the result is unchanged.
REQ-037 Reset and cfg: rst for 1 cycle mid-MAC -> the next cycle is IDLE with out_valid=0 and the next result uses zeroed weights. A cfg write while busy is dropped, and an out-of-range address leaves storage unchanged.
